// File: rtl/stable_bus_sync_if.sv
// Bundle of the asynchronous source bus and the dn_clk-domain outputs of stable_bus_sync.
// master drives the source side; slave is the synchroniser itself.
interface stable_bus_sync_if #(
  parameter int BUS_WIDTH = 32
);
  logic [BUS_WIDTH-1:0] up_bus;
  logic                 dn_hold;
  logic [BUS_WIDTH-1:0] dn_bus;
  logic                 dn_upd;
  logic                 dn_stable;
  logic                 dn_glitch;

  modport master (
    output up_bus, dn_hold,
    input  dn_bus, dn_upd, dn_stable, dn_glitch
  );

  modport slave (
    input  up_bus, dn_hold,
    output dn_bus, dn_upd, dn_stable, dn_glitch
  );
endinterface

// File: rtl/stable_bus_sync.sv
// Multi-bit synchroniser for a slowly changing asynchronous bus: republishes the
// synchronised word only after it has held unchanged for STABLE_CYCLES cycles.
module stable_bus_sync #(
  parameter int BUS_WIDTH     = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input logic               dn_clk,
  input logic               dn_rst,
  stable_bus_sync_if.slave  bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [BUS_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [BUS_WIDTH-1:0] r_prev;
  logic [CW-1:0]        r_cnt;
  logic [BUS_WIDTH-1:0] r_bus;
  logic                 r_upd;
  logic                 r_glitch;

  logic [BUS_WIDTH-1:0] w_syn;
  logic                 w_change;
  logic                 w_qual;

  assign w_syn    = r_sync[SYNC_STAGES-1];
  assign w_change = (w_syn != r_prev);
  assign w_qual   = (r_cnt == CNT_MAX);

  always_ff @(posedge dn_clk or posedge dn_rst) begin
    if (dn_rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= bus.up_bus;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_prev <= w_syn;
    end
  end

  // Run length of the synchronised word, saturating once it has qualified.
  always_ff @(posedge dn_clk or posedge dn_rst) begin
    if (dn_rst) begin
      r_cnt    <= '0;
      r_glitch <= 1'b0;
    end else begin
      if (w_change)     r_cnt <= '0;
      else if (!w_qual) r_cnt <= r_cnt + CW'(1);
      r_glitch <= w_change && !w_qual;
    end
  end

  always_ff @(posedge dn_clk or posedge dn_rst) begin
    if (dn_rst) begin
      r_bus <= '0;
      r_upd <= 1'b0;
    end else if (w_qual && !bus.dn_hold && (r_prev != r_bus)) begin
      r_bus <= r_prev;
      r_upd <= 1'b1;
    end else begin
      r_upd <= 1'b0;
    end
  end

  assign bus.dn_bus    = r_bus;
  assign bus.dn_upd    = r_upd;
  assign bus.dn_stable = w_qual;
  assign bus.dn_glitch = r_glitch;

endmodule

// File: tb/tb_stable_bus_sync.sv
// Self-checking bench for stable_bus_sync: a run-length reference model of the
// default instance plus directed latency checks on a narrow, fast-qualifying instance.
module tb_stable_bus_sync;

  localparam int S  = 2;
  localparam int ST = 4;

  logic dn_clk;
  logic dn_rst;

  stable_bus_sync_if #(.BUS_WIDTH(32)) ifa ();
  stable_bus_sync_if #(.BUS_WIDTH(1))  ifb ();

  stable_bus_sync #(.BUS_WIDTH(32), .SYNC_STAGES(S), .STABLE_CYCLES(ST)) u_a (
    .dn_clk (dn_clk),
    .dn_rst (dn_rst),
    .bus    (ifa)
  );

  stable_bus_sync #(.BUS_WIDTH(1), .SYNC_STAGES(3), .STABLE_CYCLES(1)) u_b (
    .dn_clk (dn_clk),
    .dn_rst (dn_rst),
    .bus    (ifb)
  );

  initial dn_clk = 1'b0;
  always #5 dn_clk = ~dn_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: inputs seen at each edge since reset, the edge of the last
  // detected change of the synchronised word, and the published word.
  logic [31:0] u_hist[$];
  int          n;
  int          last_chg;
  logic [31:0] m_bus;
  logic        e_upd, e_glitch, e_stable;
  int          glitch_seen, upd_seen;

  function automatic logic [31:0] syn_at(input int m);
    int k;
    k = m - S + 1;
    if (k < 1) return 32'h0;
    return u_hist[k-1];
  endfunction

  function automatic int run_len(input int edge_n);
    int r;
    r = edge_n - last_chg;
    return (r > ST) ? ST : r;
  endfunction

  task automatic model_reset();
    u_hist.delete();
    n        = 0;
    last_chg = 0;
    m_bus    = '0;
    e_upd    = 1'b0;
    e_glitch = 1'b0;
    e_stable = 1'b0;
  endtask

  task automatic model_edge();
    logic        chg;
    int          cnt_b;
    logic [31:0] prev_b;
    n++;
    u_hist.push_back(ifa.up_bus);
    chg      = (syn_at(n-1) != syn_at(n-2));
    cnt_b    = run_len(n-1);
    prev_b   = syn_at(n-2);
    e_glitch = chg && (cnt_b < ST);
    if (chg) last_chg = n;
    if (cnt_b == ST && !ifa.dn_hold && prev_b != m_bus) begin
      m_bus = prev_b;
      e_upd = 1'b1;
    end else begin
      e_upd = 1'b0;
    end
    e_stable = (run_len(n) == ST);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic check_a();
    chk("dn_bus",    ifa.dn_bus,           m_bus);
    chk("dn_upd",    32'(ifa.dn_upd),      32'(e_upd));
    chk("dn_stable", 32'(ifa.dn_stable),   32'(e_stable));
    chk("dn_glitch", 32'(ifa.dn_glitch),   32'(e_glitch));
    if (ifa.dn_upd)    upd_seen++;
    if (ifa.dn_glitch) glitch_seen++;
  endtask

  task automatic tick();
    @(posedge dn_clk);
    #1;
    model_edge();
    check_a();
  endtask

  // Asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    dn_rst = 1'b1;
    #1;
    chk("rst_bus",    ifa.dn_bus,           32'h0);
    chk("rst_upd",    32'(ifa.dn_upd),      32'h0);
    chk("rst_stable", 32'(ifa.dn_stable),   32'h0);
    chk("rst_glitch", 32'(ifa.dn_glitch),   32'h0);
    @(posedge dn_clk);
    #1;
    dn_rst = 1'b0;
    model_reset();
  endtask

  logic [31:0] v;
  int          len;

  initial begin
    dn_rst      = 1'b1;
    ifa.up_bus  = '0;
    ifa.dn_hold = 1'b0;
    ifb.up_bus  = '0;
    ifb.dn_hold = 1'b0;
    glitch_seen = 0;
    upd_seen    = 0;
    model_reset();
    @(posedge dn_clk);
    @(posedge dn_clk);
    #1;
    dn_rst = 1'b0;
    chk("init_bus",    ifa.dn_bus,         32'h0);
    chk("init_stable", 32'(ifa.dn_stable), 32'h0);

    // Constant zero qualifies without any update.
    repeat (7) tick();
    chk("zero_stable_7", 32'(ifa.dn_stable), 32'h1);
    chk("zero_no_upd",   32'(upd_seen),      32'h0);

    // Single step, published at edge 8.
    ifa.up_bus = 32'hA5A5_0F0F;
    upd_seen = 0; glitch_seen = 0;
    repeat (7) tick();
    chk("step_pre8_bus", ifa.dn_bus, 32'h0);
    tick();
    chk("step_e8_upd", 32'(ifa.dn_upd), 32'h1);
    chk("step_e8_bus", ifa.dn_bus, 32'hA5A5_0F0F);
    repeat (4) tick();
    chk("step_one_upd",    32'(upd_seen),    32'h1);
    chk("step_no_glitch",  32'(glitch_seen), 32'h0);

    // Fast toggling never qualifies; settles at 3.
    upd_seen = 0; glitch_seen = 0;
    for (int i = 0; i < 10; i++) begin
      ifa.up_bus = (i % 2 == 0) ? 32'h1 : 32'h2;
      repeat (2) tick();
    end
    chk("toggle_bus_kept", ifa.dn_bus, 32'hA5A5_0F0F);
    ifa.up_bus = 32'h3;
    repeat (12) tick();
    chk("toggle_final_bus", ifa.dn_bus,        32'h3);
    chk("toggle_one_upd",   32'(upd_seen),     32'h1);
    chk("toggle_glitches",  32'(glitch_seen),  32'd10);

    // Hold across qualification, released 10 cycles later.
    ifa.dn_hold = 1'b1;
    ifa.up_bus  = 32'h55;
    upd_seen = 0;
    repeat (17) tick();
    chk("hold_frozen", ifa.dn_bus, 32'h3);
    ifa.dn_hold = 1'b0;
    tick();
    chk("hold_rel_upd", 32'(ifa.dn_upd), 32'h1);
    chk("hold_rel_bus", ifa.dn_bus,      32'h55);
    repeat (3) tick();
    chk("hold_one_upd", 32'(upd_seen), 32'h1);

    // Reset while the new candidate is two cycles into qualification.
    ifa.up_bus = 32'hFF;
    repeat (5) tick();
    do_reset();
    tick();
    chk("rst_exit_upd",    32'(ifa.dn_upd),    32'h0);
    chk("rst_exit_glitch", 32'(ifa.dn_glitch), 32'h0);
    repeat (6) tick();
    chk("rst_pre8_bus", ifa.dn_bus, 32'h0);
    tick();
    chk("rst_e8_bus", ifa.dn_bus, 32'hFF);

    // Narrow instance: 3 sync stages, single-cycle qualification.
    do_reset();
    ifb.up_bus = 1'b0;
    repeat (3) tick();
    ifb.up_bus = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("b_upd_e%0d", e), 32'(ifb.dn_upd), (e == 6) ? 32'h1 : 32'h0);
    end
    chk("b_bus", 32'(ifb.dn_bus), 32'h1);

    // Randomised segments against the model.
    for (int seg = 0; seg < 200; seg++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = ifa.up_bus ^ (32'h1 << $urandom_range(0, 31));
        2:       v = ifa.up_bus;
        default: v = {28'h0, 4'($urandom)};
      endcase
      ifa.up_bus  = v;
      ifa.dn_hold = ($urandom_range(0, 5) == 0);
      len = $urandom_range(1, 10);
      repeat (len) tick();
      if ($urandom_range(0, 39) == 0) do_reset();
    end
    ifa.dn_hold = 1'b0;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
